keypad_scan: RTL and testbench
==============================

# keypad_scan

Column-scanned 4x4 matrix keypad reader for the board I/O subsystem. It is the input-side counterpart of the multiplexed 7-segment display driver. It walks one active-low column at a time and samples the synchronized active-low rows. Each press and each release is debounced over consecutive scan samples. Each debounced press is delivered as a 4-bit hex key code through a single-entry valid/ready holding register, so codes feed directly into the display's nibble-coded digit bus.

## Interface
Parameters:
- SCAN_DIV_BITS, 16: column dwell is 2^SCAN_DIV_BITS cycles; legal range ≥ 2.
- DEBOUNCE_SCANS, 4: consecutive agreeing samples needed to accept a press or a release; legal range ≥ 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- row  in  4  keypad rows, active-low, asynchronous to clk
- col  out  4  column drive, active-low, exactly one bit low
- key_code  out  4  code of accepted key, row_idx*4 + col_idx
- key_valid  out  1  holding register full
- key_ready  in  1  consumer accepts key_code when key_valid & key_ready
- key_held  out  1  accepted key still down (state HELD)
- overflow  out  1  sticky: a press was dropped because the holding register was full
- ovf_clr  in  1  clears overflow

## Operation
- Row synchronizer: 2 flops, reset to 4'hF; all decisions use the synchronized value row_s.
- Dwell counter div (SCAN_DIV_BITS wide) free-runs and wraps. The sample cycle is the cycle where div is all ones. All FSM, column and counter updates below happen only on sample cycles.
- col = ~(4'b0001 << col_idx). col_idx is 2 bits, wraps 3→0.
- State SCAN:
  - row_s == 4'hF: col_idx++.
  - Otherwise: latch row_idx = lowest-numbered low row, freeze col_idx, deb_cnt = 1.
    - DEBOUNCE_SCANS == 1: emit, go to HELD.
    - Else: go to DEBOUNCE.
- State DEBOUNCE:
  - row_s[row_idx] == 0: deb_cnt++. On reaching DEBOUNCE_SCANS, emit and go to HELD.
  - row_s[row_idx] == 1: col_idx++, go to SCAN (bounce rejected, no emit).
- State HELD:
  - key_held = 1. Other keys are ignored.
  - row_s[row_idx] == 1: rel_cnt++. On reaching DEBOUNCE_SCANS, col_idx++ and go to SCAN.
  - row_s[row_idx] == 0: rel_cnt = 0.
- rel_cnt is cleared on entry to HELD.
- Emit: produces code {row_idx, col_idx}.
  - Register empty, or being consumed in the same cycle (key_valid & key_ready): load key_code, key_valid = 1.
  - Register full and not consumed: drop the new code, keep key_code unchanged, set overflow.
- Handshake: key_valid & key_ready at an edge clears key_valid, unless an emit refills it at that same edge. key_code is stable while key_valid = 1.
- overflow: ovf_clr clears it. If ovf_clr and a drop happen in the same cycle, the set wins.
- Counter widths: deb_cnt and rel_cnt are $clog2(DEBOUNCE_SCANS+1) bits and saturate. No other arithmetic.

## Timing
- Reset values: col = 4'hE, key_code = 4'h0, key_valid = 0, key_held = 0, overflow = 0. State = SCAN, div = 0, col_idx = 0, counters = 0.
- Reset applies immediately when asserted and is honored mid-press. A pending key is discarded, not emitted.
- After reset, a key held down is detected fresh by the normal press sequence.
- Sample period T = 2^SCAN_DIV_BITS cycles. The first sample after reset is at div = all ones, i.e. cycle 2^SCAN_DIV_BITS − 1.
- col changes only at the edge ending a sample cycle. The 2-flop synchronizer therefore settles well within the ≥ 4-cycle dwell.
- Press latency: key_valid rises at the edge of the DEBOUNCE_SCANS-th consecutive low sample, counted from the first detecting sample.
- key_held rises at that same edge.
- Release latency: key_held falls at the edge of the DEBOUNCE_SCANS-th consecutive high sample.
- Worst-case detection delay from press: 4T for column rotation, plus debounce time.

## Test plan
Common setup: SCAN_DIV_BITS = 2 (T = 4), DEBOUNCE_SCANS = 3. The bench models the keypad as row[r] = 0 when col[c] = 0 for pressed key (r, c).
- Reset then idle, no key: col sequence E, D, B, 7, E… with each value held 4 cycles; key_valid, key_held and overflow stay 0; all outputs take their reset values during rst_n = 0.
- Press key (2, 1) steadily, key_ready = 1 → key_code = 4'h9; key_valid pulses for one cycle at the 3rd consecutive low sample; key_held = 1; col frozen at D.
- Release (2, 1) → key_held falls at the 3rd consecutive high sample; scanning resumes with col = B.
- Bounce test: press (0, 3) low for exactly 2 samples, then high → no emit; scan resumes with col = E.
- Backpressure: key_ready = 0, press and release key 5, then key 6 → key_code stays 4'h5 and overflow = 1. Then key_ready = 1 consumes the code, and ovf_clr clears overflow.
- Simultaneous events and mid-press reset: key_ready asserted in the same cycle as an emit → the new code loads and overflow stays 0. Then assert rst_n = 0 mid-DEBOUNCE → reset values take effect immediately and no code is emitted.

Source files
------------

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - column-scanned 4x4 keypad reader with debounce and a one-entry key holding register
module keypad_scan #(
  parameter int SCAN_DIV_BITS  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] ST_SCAN = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

  logic [3:0]               row_meta_q, row_meta_d;
  logic [3:0]               row_s_q, row_s_d;
  logic [SCAN_DIV_BITS-1:0] div_q, div_d;
  logic [1:0]               state_q, state_d;
  logic [1:0]               col_idx_q, col_idx_d;
  logic [1:0]               row_idx_q, row_idx_d;
  logic [CW-1:0]            deb_cnt_q, deb_cnt_d;
  logic [CW-1:0]            rel_cnt_q, rel_cnt_d;
  logic [3:0]               key_code_q, key_code_d;
  logic                     key_valid_q, key_valid_d;
  logic                     overflow_q, overflow_d;

  logic       sample;
  logic       emit;
  logic       consume;
  logic [1:0] first_low;

  assign sample  = &div_q;
  assign consume = key_valid_q & key_ready;

  // Lowest-numbered row wins when several rows are pulled low at once.
  always_comb begin
    first_low = 2'd3;
    if (!row_s_q[2]) first_low = 2'd2;
    if (!row_s_q[1]) first_low = 2'd1;
    if (!row_s_q[0]) first_low = 2'd0;
  end

  always_comb begin
    row_meta_d  = row;
    row_s_d     = row_meta_q;
    div_d       = div_q + SCAN_DIV_BITS'(1);
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overflow_d  = overflow_q;
    emit        = 1'b0;

    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (row_s_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = first_low;
            deb_cnt_d = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              emit      = 1'b1;
              state_d   = ST_HELD;
              rel_cnt_d = '0;
            end else begin
              state_d = ST_DEB;
            end
          end
        end
        ST_DEB: begin
          if (!row_s_q[row_idx_q]) begin
            if (deb_cnt_q != DEB_MAX) deb_cnt_d = deb_cnt_q + CNT_ONE;
            if (deb_cnt_q == DEB_MAX - CNT_ONE) begin
              emit      = 1'b1;
              state_d   = ST_HELD;
              rel_cnt_d = '0;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (row_s_q[row_idx_q]) begin
            if (rel_cnt_q != DEB_MAX) rel_cnt_d = rel_cnt_q + CNT_ONE;
            if (rel_cnt_q == DEB_MAX - CNT_ONE) begin
              col_idx_d = col_idx_q + 2'd1;
              state_d   = ST_SCAN;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    if (consume) key_valid_d = 1'b0;
    if (ovf_clr) overflow_d = 1'b0;

    // A drop sets overflow after the clear so a simultaneous drop is never lost.
    if (emit) begin
      if (!key_valid_q || consume) begin
        key_code_d  = {row_idx_d, col_idx_q};
        key_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q  <= 4'hF;
      row_s_q     <= 4'hF;
      div_q       <= '0;
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      row_meta_q  <= row_meta_d;
      row_s_q     <= row_s_d;
      div_q       <= div_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == ST_HELD);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed/randomized bench for keypad_scan against a sample-level timing model
module tb_keypad_scan;

  localparam int DS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overflow;
  logic       ovf_clr;

  logic       kp_on;
  logic [1:0] kp_r;
  logic [1:0] kp_c;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base_p   = 0;
  int base_c   = 0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV_BITS(2), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  // Pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    if (kp_on && (col[kp_c] == 1'b0)) row[kp_r] = 1'b0;
  end

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] col_of(input int c);
    logic [3:0] m;
    m = 4'b0001 << c[1:0];
    return ~m;
  endfunction

  // Column active during scan period p, counted from the last point scanning resumed.
  function automatic int col_at(input int p);
    return (base_c + p - base_p) % 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic press_key(input int r, input int c, input int gap, input logic [3:0] code_exp,
                           input logic ovf_exp, input logic rdy, input logic valid_pre);
    int p0;
    int d;
    int e;
    p0 = (cyc + 3) / 4 + gap;
    to_cyc(4 * p0);
    kp_r  = r[1:0];
    kp_c  = c[1:0];
    kp_on = 1'b1;
    d = p0 + (c - col_at(p0) + 4) % 4;
    e = 4 * (d + DS);
    to_cyc(e - 1);
    chk1("pre_emit_held", key_held, 1'b0);
    chk1("pre_emit_valid", key_valid, valid_pre);
    key_ready = rdy;
    tick();
    chk1("emit_valid", key_valid, 1'b1);
    chk4("emit_code", key_code, code_exp);
    chk1("emit_held", key_held, 1'b1);
    chk4("emit_col", col, col_of(c));
    chk1("emit_ovf", overflow, ovf_exp);
  endtask

  task automatic release_key(input int gap, input int c);
    int q;
    int f;
    q = (cyc + 3) / 4 + gap;
    to_cyc(4 * q);
    kp_on = 1'b0;
    f = 4 * (q + DS);
    to_cyc(f - 1);
    chk1("pre_release_held", key_held, 1'b1);
    tick();
    chk1("release_held", key_held, 1'b0);
    chk4("release_col", col, col_of(c + 1));
    base_p = q + DS;
    base_c = (c + 1) % 4;
  endtask

  initial begin
    int r;
    int c;
    int r2;
    int c2;
    int p0;
    int d;

    rst_n     = 1'b0;
    kp_on     = 1'b0;
    kp_r      = 2'd0;
    kp_c      = 2'd0;
    key_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (3) tick();
    chk4("rst_col", col, 4'hE);
    chk4("rst_code", key_code, 4'h0);
    chk1("rst_valid", key_valid, 1'b0);
    chk1("rst_held", key_held, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);

    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 20; i++) begin
      chk4("idle_col", col, col_of((cyc / 4) % 4));
      chk4("idle_flags", {1'b0, key_valid, key_held, overflow}, 4'h0);
      tick();
    end

    press_key(2, 1, 0, 4'h9, 1'b0, 1'b1, 1'b0);
    tick();
    chk1("consumed_valid", key_valid, 1'b0);
    chk4("frozen_col", col, 4'hD);
    release_key(1, 1);

    p0 = (cyc + 3) / 4;
    to_cyc(4 * p0);
    kp_r  = 2'd0;
    kp_c  = 2'd3;
    kp_on = 1'b1;
    d = p0 + (3 - col_at(p0) + 4) % 4;
    to_cyc(4 * (d + 2));
    chk1("bounce_valid_mid", key_valid, 1'b0);
    kp_on = 1'b0;
    to_cyc(4 * (d + 3) - 1);
    chk1("bounce_held", key_held, 1'b0);
    tick();
    chk4("bounce_col", col, 4'hE);
    chk1("bounce_valid", key_valid, 1'b0);
    base_p = d + 3;
    base_c = 0;

    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      press_key(r, c, int'($urandom_range(0, 3)), 4'(r * 4 + c), 1'b0, 1'b1, 1'b0);
      tick();
      chk1("rand_consumed", key_valid, 1'b0);
      release_key(int'($urandom_range(0, 2)), c);
    end

    key_ready = 1'b0;
    press_key(1, 1, 0, 4'h5, 1'b0, 1'b0, 1'b0);
    tick();
    chk1("bp_valid_hold", key_valid, 1'b1);
    release_key(0, 1);
    press_key(1, 2, 1, 4'h5, 1'b1, 1'b0, 1'b1);
    release_key(0, 2);
    chk4("bp_code_kept", key_code, 4'h5);
    key_ready = 1'b1;
    tick();
    chk1("bp_consumed", key_valid, 1'b0);
    chk1("bp_ovf_sticky", overflow, 1'b1);
    key_ready = 1'b0;
    ovf_clr   = 1'b1;
    tick();
    chk1("bp_ovf_clr", overflow, 1'b0);
    ovf_clr = 1'b0;

    r  = int'($urandom_range(0, 3));
    c  = int'($urandom_range(0, 3));
    r2 = int'($urandom_range(0, 3));
    c2 = int'($urandom_range(0, 3));
    press_key(r, c, 0, 4'(r * 4 + c), 1'b0, 1'b0, 1'b0);
    release_key(0, c);
    press_key(r2, c2, 0, 4'(r2 * 4 + c2), 1'b0, 1'b1, 1'b1);
    tick();
    chk1("simul_consumed", key_valid, 1'b0);
    release_key(0, c2);

    key_ready = 1'b1;
    r = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    p0 = (cyc + 3) / 4;
    to_cyc(4 * p0);
    kp_r  = r[1:0];
    kp_c  = c[1:0];
    kp_on = 1'b1;
    d = p0 + (c - col_at(p0) + 4) % 4;
    to_cyc(4 * (d + 1) + 1);
    rst_n = 1'b0;
    #1;
    chk4("midrst_col", col, 4'hE);
    chk4("midrst_code", key_code, 4'h0);
    chk1("midrst_valid", key_valid, 1'b0);
    chk1("midrst_held", key_held, 1'b0);
    chk1("midrst_ovf", overflow, 1'b0);
    tick();
    tick();
    chk1("midrst_no_emit", key_valid, 1'b0);
    rst_n  = 1'b1;
    cyc    = 0;
    base_p = 0;
    base_c = 0;
    press_key(r, c, 0, 4'(r * 4 + c), 1'b0, 1'b1, 1'b0);
    tick();
    chk1("fresh_consumed", key_valid, 1'b0);
    release_key(0, c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
